// File: rtl/alu_sweep_collector.sv
// ---------------------------------------------------------------------------
// alu_sweep_collector
//
// Purpose:
//   Drives an external 8-bit ALU through all 16 opcodes for one pair of
//   operands. Each opcode is held for SETTLE wait cycles plus one capture
//   cycle. The block stores every {carry, result} pair in a 16-entry buffer
//   and keeps a running mod-256 checksum of the results.
//
// Parameters:
//   SETTLE    : wait cycles each opcode is held before capture (0..15)
//
// Ports:
//   clk       : in  single clock, rising-edge
//   rst_n     : in  synchronous active-low reset
//   start     : in  request a sweep (ignored while busy)
//   op_a/op_b : in  operands, sampled when start is accepted
//   alu_a/b   : out operands driven to the external ALU
//   alu_sel   : out opcode driven to the external ALU
//   alu_out   : in  ALU result
//   alu_carry : in  ALU carry-out
//   busy      : out sweep in progress
//   done      : out sweep finished; cleared by the next accepted start or reset
//   rd_addr   : in  result buffer read index
//   rd_data   : out {carry, result} for opcode rd_addr (combinational)
//   checksum  : out sum mod 256 of the results captured in this sweep
// ---------------------------------------------------------------------------
module alu_sweep_collector #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    output logic       busy,
    output logic       done,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic [7:0] checksum
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

    // With SETTLE=0 there is no wait phase. Each opcode then lives in CAPTURE
    // for its single cycle, so a sweep still takes 16*(SETTLE+1) cycles.
    localparam state_t     OP_ENTRY    = (SETTLE == 0) ? CAPTURE : WAIT;
    localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    state_t     state;
    state_t     state_next;
    logic       accept;
    logic [3:0] settle_cnt;
    logic [8:0] buffer [16];

    // Next-state logic. A start is only honoured from IDLE or DONE, which
    // makes starts that arrive mid-sweep fall through harmlessly.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = OP_ENTRY;
                end
            end
            WAIT: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (alu_sel == 4'hF) begin
                    state_next = DONE;
                end else begin
                    state_next = OP_ENTRY;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers. Reset clears everything, including the
    // whole result buffer. A new sweep does not clear the buffer: entries that
    // have not been captured yet keep their value from the previous sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            settle_cnt <= '0;
            checksum   <= '0;
            for (int i = 0; i < 16; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (accept) begin
                alu_a      <= op_a;
                alu_b      <= op_b;
                alu_sel    <= '0;
                settle_cnt <= '0;
                checksum   <= '0;
            end else begin
                case (state)
                    WAIT: begin
                        if (state_next == WAIT) begin
                            settle_cnt <= settle_cnt + 4'd1;
                        end
                    end
                    CAPTURE: begin
                        buffer[alu_sel] <= {alu_carry, alu_out};
                        checksum        <= checksum + alu_out;
                        // alu_sel stays at 15 once the last opcode is captured
                        if (alu_sel != 4'hF) begin
                            alu_sel    <= alu_sel + 4'd1;
                            settle_cnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy    = (state == WAIT) || (state == CAPTURE);
    assign done    = (state == DONE);
    assign rd_data = buffer[rd_addr];

endmodule

// File: tb/tb_alu_sweep_collector.sv
// ---------------------------------------------------------------------------
// tb_alu_sweep_collector
//
// Two instances (SETTLE=1 and SETTLE=0) each drive a behavioural ALU:
//   alu_out = alu_a + alu_sel, alu_carry = alu_sel[0].
// Expected buffer entries are queued when a sweep is started. They are popped
// and compared once the DUT signals done.
// ---------------------------------------------------------------------------
module tb_alu_sweep_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       sel_dut;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [3:0] rd_addr;

    logic       start1, start0;
    logic [7:0] alu_a1, alu_b1, alu_out1, checksum1;
    logic [7:0] alu_a0, alu_b0, alu_out0, checksum0;
    logic [3:0] alu_sel1, alu_sel0;
    logic       alu_carry1, alu_carry0;
    logic       busy1, busy0, done1, done0;
    logic [8:0] rd_data1, rd_data0;

    // Start is routed only to the instance currently under test.
    assign start1 = start & sel_dut;
    assign start0 = start & ~sel_dut;

    // Behavioural external ALUs
    assign alu_out1   = alu_a1 + {4'h0, alu_sel1};
    assign alu_carry1 = alu_sel1[0];
    assign alu_out0   = alu_a0 + {4'h0, alu_sel0};
    assign alu_carry0 = alu_sel0[0];

    alu_sweep_collector #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a), .op_b(op_b),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1),
        .alu_out(alu_out1), .alu_carry(alu_carry1),
        .busy(busy1), .done(done1), .rd_addr(rd_addr),
        .rd_data(rd_data1), .checksum(checksum1)
    );

    alu_sweep_collector #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .op_a(op_a), .op_b(op_b),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_sel(alu_sel0),
        .alu_out(alu_out0), .alu_carry(alu_carry0),
        .busy(busy0), .done(done0), .rd_addr(rd_addr),
        .rd_data(rd_data0), .checksum(checksum0)
    );

    // View of the instance under test
    logic       busy_s, done_s;
    logic [7:0] checksum_s, alu_a_s;
    logic [3:0] alu_sel_s;
    logic [8:0] rd_data_s;
    assign busy_s     = sel_dut ? busy1     : busy0;
    assign done_s     = sel_dut ? done1     : done0;
    assign checksum_s = sel_dut ? checksum1 : checksum0;
    assign alu_a_s    = sel_dut ? alu_a1    : alu_a0;
    assign alu_sel_s  = sel_dut ? alu_sel1  : alu_sel0;
    assign rd_data_s  = sel_dut ? rd_data1  : rd_data0;

    typedef struct {
        logic [3:0] addr;
        logic [8:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_checksum;
    int         tests_run    = 0;
    int         tests_failed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle start. Returns 1ns after the edge that accepts it.
    task automatic pulseStart(input logic which, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        sel_dut = which;
        op_a    = a;
        op_b    = b;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_start", busy_s, 1'b1);
        checkOutput("alu_a_latched", alu_a_s, a);
        checkOutput("alu_sel_start", alu_sel_s, 4'h0);
        checkOutput("done_cleared", done_s, 1'b0);
    endtask

    // Queue the model's expected buffer contents, then start the sweep.
    task automatic applyStimulus(input logic which, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] cks);
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] kk;
            logic [7:0] sum8;
            kk     = 4'(k);
            sum8   = a + {4'h0, kk};
            e.addr = kk;
            e.data = {kk[0], sum8};
            sb.push_back(e);
        end
        exp_checksum = cks;
        pulseStart(which, a, b);
    endtask

    // Count edges after the accepting edge until done rises. The count is
    // bounded, so a sweep that never finishes shows up as a latency failure.
    task automatic waitDone(input int start_n, input int expected);
        int n;
        n = start_n;
        while (done_s !== 1'b1 && n < 300) begin
            @(posedge clk);
            n++;
            #1;
        end
        checkOutput("done_latency", n, expected);
        checkOutput("busy_at_done", busy_s, 1'b0);
        checkOutput("alu_sel_hold", alu_sel_s, 4'hF);
    endtask

    task automatic drainScoreboard();
        exp_t e;
        while (sb.size() > 0) begin
            e       = sb.pop_front();
            rd_addr = e.addr;
            #1;
            checkOutput($sformatf("rd_data[%0d]", e.addr), rd_data_s, e.data);
        end
        checkOutput("checksum", checksum_s, exp_checksum);
    endtask

    task automatic checkBufferZero(input string tag);
        for (int k = 0; k < 16; k++) begin
            rd_addr = 4'(k);
            #1;
            checkOutput($sformatf("%s[%0d]", tag, k), rd_data_s, 9'h000);
        end
    endtask

    initial begin
        int done_seen;
        rst_n   = 1'b0;
        start   = 1'b0;
        sel_dut = 1'b1;
        op_a    = 8'h00;
        op_b    = 8'h00;
        rd_addr = 4'h0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state and idle behaviour for both instances
        for (int w = 0; w < 2; w++) begin
            sel_dut = w[0];
            checkOutput("rst_busy", busy_s, 1'b0);
            checkOutput("rst_done", done_s, 1'b0);
            checkOutput("rst_checksum", checksum_s, 8'h00);
            checkOutput("rst_alu_a", alu_a_s, 8'h00);
            checkOutput("rst_alu_sel", alu_sel_s, 4'h0);
            checkBufferZero("rst_buf");
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("idle_busy", {busy1, busy0}, 2'b00);
        checkOutput("idle_done", {done1, done0}, 2'b00);

        // Basic sweep, SETTLE=1
        applyStimulus(1'b1, 8'h0A, 8'h02, 8'h18);
        waitDone(0, 32);
        drainScoreboard();

        // Start re-pulsed mid-sweep must be ignored
        applyStimulus(1'b1, 8'h0A, 8'h02, 8'h18);
        repeat (4) @(posedge clk);
        @(negedge clk);
        op_a  = 8'hF6;
        op_b  = 8'h33;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("restart_busy", busy_s, 1'b1);
        checkOutput("restart_alu_a", alu_a_s, 8'h0A);
        checkOutput("restart_alu_b", alu_b1, 8'h02);
        waitDone(5, 32);
        drainScoreboard();

        // New sweep from DONE with wrapping sums; entry 15 keeps its old value until rewritten
        applyStimulus(1'b1, 8'hF6, 8'h02, 8'hD8);
        rd_addr = 4'hF;
        #1;
        checkOutput("rd_prior15", rd_data_s, 9'h119);
        waitDone(0, 32);
        rd_addr = 4'hF;
        #1;
        checkOutput("rd_wrap15", rd_data_s, 9'h105);
        drainScoreboard();

        // Reset mid-sweep, asserted together with start
        pulseStart(1'b1, 8'h21, 8'h07);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        checkOutput("abort_busy", busy_s, 1'b0);
        checkOutput("abort_done", done_s, 1'b0);
        checkOutput("abort_checksum", checksum_s, 8'h00);
        checkOutput("abort_alu_a", alu_a_s, 8'h00);
        checkOutput("abort_alu_sel", alu_sel_s, 4'h0);
        checkBufferZero("abort_buf");
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done1 === 1'b1 || busy1 === 1'b1) done_seen++;
        end
        checkOutput("abort_no_done", done_seen, 0);

        // SETTLE=0 instance
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h78);
        waitDone(0, 16);
        drainScoreboard();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
